// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the I-cache, D-cache and main-memory signals of the
// line-memory arbiter.
//   slave  modport : arbiter side (takes requests and memory read data;
//                    drives done/rdata, memory controls and busy)
//   master modport : environment side (caches plus memory), the mirror image
interface mem_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int LINE_W = 64
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [LINE_W-1:0] i_rdata;
  logic              d_req;
  logic              d_dirty;
  logic [ADDR_W-1:0] d_addr;
  logic [ADDR_W-1:0] d_wb_addr;
  logic [LINE_W-1:0] d_wb_data;
  logic              d_done;
  logic [LINE_W-1:0] d_rdata;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_dirty, d_addr, d_wb_addr, d_wb_data, mem_rdata,
    output i_done, i_rdata, d_done, d_rdata, mem_re, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_dirty, d_addr, d_wb_addr, d_wb_data, mem_rdata,
    input  i_done, i_rdata, d_done, d_rdata, mem_re, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency line memory between the I-cache and
// D-cache miss handlers. A dirty D-cache miss runs writeback then fill as one
// atomic grant. Every output is a register loaded from the next-state decode.
//   clk  : clock, rising edge
//   rst  : synchronous reset, active high
//   bus  : mem_arbiter_if.slave (request/done/rdata per cache, memory port, busy)
module mem_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int LINE_W   = 64,
  parameter int MEM_LAT  = 4,
  parameter int ARB_MODE = 0
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_I_RD = 3'd1,
    ST_D_WB = 3'd2,
    ST_D_RD = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);
  localparam bit         RR_MODE  = (ARB_MODE == 1);

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt;
  logic              r_gnt_d;   // current grant belongs to the D-cache
  logic              r_last_d;  // last grant went to the D-cache
  logic [ADDR_W-1:0] r_i_addr, r_d_addr, r_wb_addr;
  logic [LINE_W-1:0] r_wb_data;

  logic              r_i_done, r_d_done, r_mem_re, r_mem_we, r_busy;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_wdata, r_i_rdata, r_d_rdata;

  logic              w_pick_d, w_grant, w_cnt_last;
  logic              w_i_done, w_d_done, w_mem_re, w_mem_we, w_busy;
  logic [ADDR_W-1:0] w_mem_addr, w_i_addr, w_d_addr, w_wb_addr;
  logic [LINE_W-1:0] w_mem_wdata, w_wb_data;

  // Arbitration choice among the live request lines.
  always_comb begin
    w_pick_d = 1'b0;
    if (bus.d_req && bus.i_req) begin
      w_pick_d = RR_MODE ? !r_last_d : 1'b1;
    end else if (bus.d_req) begin
      w_pick_d = 1'b1;
    end else begin
      w_pick_d = 1'b0;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_cnt_last  = (r_cnt == CNT_LAST);
    case (r_state)
      ST_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          w_grant = 1'b1;
          if (w_pick_d) begin
            w_state_nxt = bus.d_dirty ? ST_D_WB : ST_D_RD;
          end else begin
            w_state_nxt = ST_I_RD;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_I_RD, ST_D_RD: begin
        if (w_cnt_last) w_state_nxt = ST_RESP;
        else            w_state_nxt = r_state;
      end
      ST_D_WB: begin
        // Fill follows writeback directly so the I-cache cannot slip in.
        if (w_cnt_last) w_state_nxt = ST_D_RD;
        else            w_state_nxt = ST_D_WB;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the next state; on the grant cycle the addresses come
  // straight from the request inputs because the latches load on that edge.
  always_comb begin
    w_i_addr    = w_grant ? bus.i_addr    : r_i_addr;
    w_d_addr    = w_grant ? bus.d_addr    : r_d_addr;
    w_wb_addr   = w_grant ? bus.d_wb_addr : r_wb_addr;
    w_wb_data   = w_grant ? bus.d_wb_data : r_wb_data;
    w_mem_re    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = {ADDR_W{1'b0}};
    w_mem_wdata = {LINE_W{1'b0}};
    w_i_done    = 1'b0;
    w_d_done    = 1'b0;
    w_busy      = (w_state_nxt != ST_IDLE);
    case (w_state_nxt)
      ST_I_RD: begin
        w_mem_re   = 1'b1;
        w_mem_addr = w_i_addr;
      end
      ST_D_RD: begin
        w_mem_re   = 1'b1;
        w_mem_addr = w_d_addr;
      end
      ST_D_WB: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = w_wb_addr;
        w_mem_wdata = w_wb_data;
      end
      ST_RESP: begin
        w_i_done = !r_gnt_d;
        w_d_done = r_gnt_d;
      end
      default: begin
        w_mem_re = 1'b0;
      end
    endcase
  end

  // State, counter, request latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_gnt_d     <= 1'b0;
      r_last_d    <= 1'b0;
      r_i_addr    <= {ADDR_W{1'b0}};
      r_d_addr    <= {ADDR_W{1'b0}};
      r_wb_addr   <= {ADDR_W{1'b0}};
      r_wb_data   <= {LINE_W{1'b0}};
      r_i_done    <= 1'b0;
      r_d_done    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= {LINE_W{1'b0}};
      r_i_rdata   <= {LINE_W{1'b0}};
      r_d_rdata   <= {LINE_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      // Cleared on every state entry, so each phase counts 0..MEM_LAT-1.
      if ((w_state_nxt != r_state) || (r_state == ST_IDLE)) r_cnt <= 4'd0;
      else                                                   r_cnt <= r_cnt + 4'd1;
      if (w_grant) begin
        r_gnt_d   <= w_pick_d;
        r_last_d  <= w_pick_d;
        r_i_addr  <= bus.i_addr;
        r_d_addr  <= bus.d_addr;
        r_wb_addr <= bus.d_wb_addr;
        r_wb_data <= bus.d_wb_data;
      end
      // Memory read data is only valid in the final cycle of a read.
      if ((r_state == ST_I_RD) && w_cnt_last) r_i_rdata <= bus.mem_rdata;
      if ((r_state == ST_D_RD) && w_cnt_last) r_d_rdata <= bus.mem_rdata;
      r_i_done    <= w_i_done;
      r_d_done    <= w_d_done;
      r_mem_re    <= w_mem_re;
      r_mem_we    <= w_mem_we;
      r_busy      <= w_busy;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
    end
  end

  assign bus.i_done    = r_i_done;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_done    = r_d_done;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.mem_re    = r_mem_re;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiters (index 0: fixed D priority, index 1: round
// robin), each with its own memory model that presents the line only in the
// last read cycle. Table of single-requester transactions plus hand-written
// sequences for tie-breaking, early req drop and mid-transaction reset.
module tb_mem_arbiter;
  localparam int AW = 14;
  localparam int LW = 64;
  localparam int L  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          i_req_v[2], d_req_v[2], d_dirty_v[2];
  logic [AW-1:0] i_addr_v[2], d_addr_v[2], d_wb_addr_v[2];
  logic [LW-1:0] d_wb_data_v[2], mem_line_v[2];
  logic          i_done_v[2], d_done_v[2], mem_re_v[2], mem_we_v[2], busy_v[2];
  logic [AW-1:0] mem_addr_v[2];
  logic [LW-1:0] i_rdata_v[2], d_rdata_v[2], mem_wdata_v[2];
  logic [LW-1:0] last_i[2], last_d[2];

  mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus [2] ();

  for (genvar g = 0; g < 2; g++) begin : g_dut
    int            rd_cnt  = 0;
    int            both_hi = 0;
    logic [LW-1:0] mem_rd  = '0;

    assign bus[g].i_req     = i_req_v[g];
    assign bus[g].i_addr    = i_addr_v[g];
    assign bus[g].d_req     = d_req_v[g];
    assign bus[g].d_dirty   = d_dirty_v[g];
    assign bus[g].d_addr    = d_addr_v[g];
    assign bus[g].d_wb_addr = d_wb_addr_v[g];
    assign bus[g].d_wb_data = d_wb_data_v[g];
    assign bus[g].mem_rdata = mem_rd;
    assign i_done_v[g]      = bus[g].i_done;
    assign i_rdata_v[g]     = bus[g].i_rdata;
    assign d_done_v[g]      = bus[g].d_done;
    assign d_rdata_v[g]     = bus[g].d_rdata;
    assign mem_re_v[g]      = bus[g].mem_re;
    assign mem_we_v[g]      = bus[g].mem_we;
    assign mem_addr_v[g]    = bus[g].mem_addr;
    assign mem_wdata_v[g]   = bus[g].mem_wdata;
    assign busy_v[g]        = bus[g].busy;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LAT(L), .ARB_MODE(g)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus[g])
    );

    // Memory model: real line only in the last read cycle, inverted otherwise.
    always begin
      @(posedge clk);
      #1;
      if (mem_re_v[g] === 1'b1) rd_cnt = rd_cnt + 1;
      else                      rd_cnt = 0;
      mem_rd = (rd_cnt == L) ? mem_line_v[g] : ~mem_line_v[g];
      if (mem_re_v[g] === 1'b1 && mem_we_v[g] === 1'b1) both_hi = both_hi + 1;
    end
  end

  typedef struct {
    bit            is_d;
    bit            dirty;
    logic [AW-1:0] addr;
    logic [AW-1:0] wb_addr;
    logic [LW-1:0] wb_data;
    logic [LW-1:0] rdata;
    int            done_cyc;
  } vec_t;

  vec_t vecs[6];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input int m, input string tag);
    chk({tag, " mem_re"},    64'(mem_re_v[m]),    64'h0);
    chk({tag, " mem_we"},    64'(mem_we_v[m]),    64'h0);
    chk({tag, " busy"},      64'(busy_v[m]),      64'h0);
    chk({tag, " i_done"},    64'(i_done_v[m]),    64'h0);
    chk({tag, " d_done"},    64'(d_done_v[m]),    64'h0);
    chk({tag, " mem_addr"},  64'(mem_addr_v[m]),  64'h0);
    chk({tag, " mem_wdata"}, mem_wdata_v[m],      64'h0);
    chk({tag, " i_rdata"},   i_rdata_v[m],        64'h0);
    chk({tag, " d_rdata"},   d_rdata_v[m],        64'h0);
  endtask

  // One transaction from a lone requester, starting in an IDLE cycle (cycle 0).
  task automatic run_txn(input int m, input vec_t v, input string tag);
    bit wb;
    int rs;
    bit exp_we, exp_re;
    string t;
    wb = v.is_d && v.dirty;
    rs = wb ? L + 1 : 1;
    mem_line_v[m] = v.rdata;
    if (v.is_d) begin
      d_addr_v[m]    = v.addr;
      d_dirty_v[m]   = v.dirty;
      d_wb_addr_v[m] = v.wb_addr;
      d_wb_data_v[m] = v.wb_data;
      d_req_v[m]     = 1'b1;
    end else begin
      i_addr_v[m] = v.addr;
      i_req_v[m]  = 1'b1;
    end
    for (int k = 1; k <= v.done_cyc + 1; k++) begin
      tick();
      t = $sformatf("%s dut%0d c%0d", tag, m, k);
      exp_we = wb && (k <= L);
      exp_re = (k >= rs) && (k < rs + L);
      chk({t, " mem_we"}, 64'(mem_we_v[m]), 64'(exp_we));
      chk({t, " mem_re"}, 64'(mem_re_v[m]), 64'(exp_re));
      if (exp_we) begin
        chk({t, " wb_addr"}, 64'(mem_addr_v[m]), 64'(v.wb_addr));
        chk({t, " wdata"},   mem_wdata_v[m],     v.wb_data);
      end
      if (exp_re) chk({t, " rd_addr"}, 64'(mem_addr_v[m]), 64'(v.addr));
      chk({t, " i_done"}, 64'(i_done_v[m]), 64'(!v.is_d && (k == v.done_cyc)));
      chk({t, " d_done"}, 64'(d_done_v[m]), 64'(v.is_d && (k == v.done_cyc)));
      chk({t, " busy"},   64'(busy_v[m]),   64'(k <= v.done_cyc));
      if (k == v.done_cyc) begin
        if (v.is_d) begin
          chk({t, " d_rdata"}, d_rdata_v[m], v.rdata);
          chk({t, " i_rdata hold"}, i_rdata_v[m], last_i[m]);
          last_d[m] = v.rdata;
          d_req_v[m] = 1'b0;
        end else begin
          chk({t, " i_rdata"}, i_rdata_v[m], v.rdata);
          chk({t, " d_rdata hold"}, d_rdata_v[m], last_d[m]);
          last_i[m] = v.rdata;
          i_req_v[m] = 1'b0;
        end
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      last_i[m] = '0;
      last_d[m] = '0;
    end
  endtask

  initial begin
    int d_cyc, i_cyc, cnt;
    int n_done[2];
    bit order[2][4];
    bit raise_i[2], raise_d[2];

    vecs[0] = '{1'b0, 1'b0, 14'h0123, 14'h0000, 64'h0, 64'hDEAD_BEEF_0000_1111, 5};
    vecs[1] = '{1'b1, 1'b0, 14'h0040, 14'h0000, 64'h0, 64'h0123_4567_89AB_CDEF, 5};
    vecs[2] = '{1'b1, 1'b1, 14'h0041, 14'h0200, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0F0F_0F0F_1234_5678, 9};
    vecs[3] = '{1'b0, 1'b0, 14'h3FFF, 14'h0000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 5};
    vecs[4] = '{1'b1, 1'b1, 14'h0000, 14'h3FFF, 64'h0, 64'h5A5A_5A5A_5A5A_5A5A, 9};
    vecs[5] = '{1'b0, 1'b0, 14'h0000, 14'h0000, 64'h0, 64'h8000_0000_0000_0001, 5};

    for (int m = 0; m < 2; m++) begin
      i_req_v[m] = 1'b0; d_req_v[m] = 1'b0; d_dirty_v[m] = 1'b0;
      i_addr_v[m] = '0; d_addr_v[m] = '0; d_wb_addr_v[m] = '0;
      d_wb_data_v[m] = '0; mem_line_v[m] = '0;
      last_i[m] = '0; last_d[m] = '0;
    end

    // Reset state
    pulse_reset();
    for (int m = 0; m < 2; m++) chk_zero(m, $sformatf("reset dut%0d", m));

    // Table-driven single-requester transactions on both arbiters
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 6; i++) run_txn(m, vecs[i], $sformatf("vec%0d", i));

    // Simultaneous requests under fixed priority: D first, I after the gap
    i_addr_v[0] = 14'h0111; d_addr_v[0] = 14'h0222; d_dirty_v[0] = 1'b0;
    mem_line_v[0] = 64'h1111_2222_3333_4444;
    i_req_v[0] = 1'b1; d_req_v[0] = 1'b1;
    d_cyc = -1; i_cyc = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (d_done_v[0] === 1'b1) begin d_cyc = k; d_req_v[0] = 1'b0; end
      if (i_done_v[0] === 1'b1) begin i_cyc = k; i_req_v[0] = 1'b0; end
      if (d_cyc >= 0 && i_cyc >= 0) break;
    end
    i_req_v[0] = 1'b0; d_req_v[0] = 1'b0;
    chk("tie fixed d_done cycle", 64'(d_cyc), 64'd5);
    chk("tie fixed i_done cycle", 64'(i_cyc), 64'd11);
    chk("tie fixed i_rdata", i_rdata_v[0], 64'h1111_2222_3333_4444);
    tick();

    // Request dropped early: transaction still completes with done
    i_addr_v[0] = 14'h0AAA; mem_line_v[0] = 64'hCAFE_F00D_0000_0AAA;
    i_req_v[0] = 1'b1; i_cyc = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 2) i_req_v[0] = 1'b0;
      if (i_done_v[0] === 1'b1) i_cyc = k;
    end
    chk("early drop i_done cycle", 64'(i_cyc), 64'd5);
    chk("early drop i_rdata", i_rdata_v[0], 64'hCAFE_F00D_0000_0AAA);

    // Continuous re-requests: fixed priority starves I, round robin alternates
    pulse_reset();
    for (int m = 0; m < 2; m++) begin
      i_addr_v[m] = 14'h0321; d_addr_v[m] = 14'h0654; d_dirty_v[m] = 1'b0;
      mem_line_v[m] = 64'h7777_8888_9999_AAAA;
      i_req_v[m] = 1'b1; d_req_v[m] = 1'b1;
      n_done[m] = 0; raise_i[m] = 1'b0; raise_d[m] = 1'b0;
      for (int j = 0; j < 4; j++) order[m][j] = 1'b0;
    end
    for (int k = 1; k <= 100; k++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        if (raise_i[m]) begin i_req_v[m] = 1'b1; raise_i[m] = 1'b0; end
        if (raise_d[m]) begin d_req_v[m] = 1'b1; raise_d[m] = 1'b0; end
        if (n_done[m] < 4) begin
          if (d_done_v[m] === 1'b1) begin
            order[m][n_done[m]] = 1'b1; n_done[m]++;
            d_req_v[m] = 1'b0; raise_d[m] = 1'b1;
          end else if (i_done_v[m] === 1'b1) begin
            order[m][n_done[m]] = 1'b0; n_done[m]++;
            i_req_v[m] = 1'b0; raise_i[m] = 1'b1;
          end
        end
      end
      if (n_done[0] >= 4 && n_done[1] >= 4) break;
    end
    for (int m = 0; m < 2; m++) begin
      i_req_v[m] = 1'b0; d_req_v[m] = 1'b0;
      chk($sformatf("rerequest dut%0d done count", m), 64'(n_done[m]), 64'd4);
      for (int j = 0; j < 4; j++)
        chk($sformatf("rerequest dut%0d grant%0d is_d", m, j),
            64'(order[m][j]), (m == 0) ? 64'd1 : 64'((j % 2) == 0));
    end
    for (int k = 0; k < 12; k++) tick();

    // Reset in the middle of a dirty D transaction
    pulse_reset();
    d_addr_v[0] = 14'h0041; d_wb_addr_v[0] = 14'h0200;
    d_wb_data_v[0] = 64'hA5A5_A5A5_A5A5_A5A5; d_dirty_v[0] = 1'b1;
    mem_line_v[0] = 64'h0BAD_0BAD_0BAD_0BAD;
    d_req_v[0] = 1'b1;
    tick();
    chk("midreset c1 mem_we", 64'(mem_we_v[0]), 64'd1);
    tick();
    rst = 1'b1; d_req_v[0] = 1'b0;
    tick();
    chk_zero(0, "midreset c3");
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (d_done_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || mem_re_v[0] !== 1'b0) cnt++;
    end
    chk("midreset quiet cycles", 64'(cnt), 64'd0);
    last_i[0] = '0; last_d[0] = '0;
    run_txn(0, vecs[0], "after reset");

    chk("dut0 re/we overlap", 64'(g_dut[0].both_hi), 64'd0);
    chk("dut1 re/we overlap", 64'(g_dut[1].both_hi), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
